free_tag_dispatcher: RTL and testbench

- Commit-side writer for the four banked rename freelists (CriqFreelist0..3).
- Takes up to two released physical tags per cycle from retirement and steers each to its bank, selected by tag[1:0].
- Each bank's freelist accepts one write per cycle, so each bank has a small staging FIFO that drains one tag per cycle into that freelist's Wable/Din.
- Cleared together with the freelists on pipeline flush (CriqClean).

---
 rtl/free_tag_dispatcher_if.sv | 25 ++
 rtl/free_tag_dispatcher.sv | 105 ++++++++++
 tb/tb_free_tag_dispatcher.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/free_tag_dispatcher_if.sv
// Release/freelist-write bundle for free_tag_dispatcher.
// master: commit side driving released tags and consuming the freelist writes.
// slave : the dispatcher itself.
interface free_tag_dispatcher_if #(
    parameter int TAGWIDE = 7
);
    logic                   RelValid0;
    logic [TAGWIDE-1:0]     RelTag0;
    logic                   RelValid1;
    logic [TAGWIDE-1:0]     RelTag1;
    logic                   RelReady;
    logic [3:0]             FlWable;
    logic [4*TAGWIDE-1:0]   FlDin;
    logic                   Idle;

    modport master (
        output RelValid0, RelTag0, RelValid1, RelTag1,
        input  RelReady, FlWable, FlDin, Idle
    );

    modport slave (
        input  RelValid0, RelTag0, RelValid1, RelTag1,
        output RelReady, FlWable, FlDin, Idle
    );
endinterface

// File: rtl/free_tag_dispatcher.sv
// free_tag_dispatcher: steers up to two released physical tags per cycle into
// four banked freelists (bank = tag[1:0]). Each bank has a small staging FIFO
// that drains one tag per cycle into its freelist write port.
// Optional build macro FREE_TAG_BYPASS_EN: a tag targeting an empty bank is
// written straight to the freelist in the same cycle instead of being staged.
module free_tag_dispatcher #(
    parameter int TAGWIDE   = 7,
    parameter int STAGEDEEP = 4,
    parameter int STAGEPTR  = 2
) (
    input  logic                 Clk,
    input  logic                 Rest,
    input  logic                 Flush,
    free_tag_dispatcher_if.slave rel
);
    localparam int NBANK = 4;
    localparam int CW    = STAGEPTR + 1;

    logic [NBANK-1:0]          bank_room;
    logic [NBANK-1:0]          bank_empty;
    logic [NBANK-1:0]          fl_wable;
    logic [NBANK*TAGWIDE-1:0]  fl_din;
    logic                      rel_ready;
    logic                      acc0;
    logic                      acc1;

    // Room for two more tags in every bank, since both slots may hit one bank.
    assign rel_ready = !Rest && !Flush && (&bank_room);

    // Tag 0 is accepted but never forwarded.
    assign acc0 = rel.RelValid0 && rel_ready && (rel.RelTag0 != '0);
    assign acc1 = rel.RelValid1 && rel_ready && (rel.RelTag1 != '0);

    generate
        for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
            logic [TAGWIDE-1:0]  mem_reg [STAGEDEEP];
            logic [STAGEPTR-1:0] head_reg;
            logic [STAGEPTR-1:0] tail_reg;
            logic [CW-1:0]       count_reg;
            logic [CW-1:0]       count_next;
            logic                push0;
            logic                push1;
            logic                byp;
            logic                st0;
            logic                st1;
            logic                drain;
            logic [TAGWIDE-1:0]  byp_tag;

            assign push0 = acc0 && (rel.RelTag0[1:0] == 2'(gi));
            assign push1 = acc1 && (rel.RelTag1[1:0] == 2'(gi));

`ifdef FREE_TAG_BYPASS_EN
            // Empty bank: the older arriving tag goes straight out this cycle.
            assign byp = (count_reg == '0) && (push0 || push1) && !Flush;
`else
            assign byp = 1'b0;
`endif
            assign byp_tag = push0 ? rel.RelTag0 : rel.RelTag1;

            // Whatever did not bypass gets staged, slot 0 ahead of slot 1.
            assign st0 = push0 && !byp;
            assign st1 = push1 && !(byp && !push0);

            assign drain = (count_reg != '0) && !Flush && !Rest;

            assign count_next = count_reg + CW'(st0) + CW'(st1) - CW'(drain);

            // Head/tail/count bookkeeping; reset and flush both empty the bank.
            always_ff @(posedge Clk) begin
                if (Rest || Flush) begin
                    head_reg  <= '0;
                    tail_reg  <= '0;
                    count_reg <= '0;
                end else begin
                    tail_reg  <= tail_reg + STAGEPTR'(st0) + STAGEPTR'(st1);
                    if (drain) begin
                        head_reg <= head_reg + STAGEPTR'(1);
                    end
                    count_reg <= count_next;
                end
            end

            // Staging storage; writes are only possible when not in reset/flush.
            always_ff @(posedge Clk) begin
                if (st0) begin
                    mem_reg[tail_reg] <= rel.RelTag0;
                end
                if (st1) begin
                    mem_reg[tail_reg + STAGEPTR'(st0)] <= rel.RelTag1;
                end
            end

            assign bank_room[gi]  = (count_reg <= CW'(STAGEDEEP - 2));
            assign bank_empty[gi] = (count_reg == '0);
            assign fl_wable[gi]   = drain || byp;
            assign fl_din[gi*TAGWIDE +: TAGWIDE] = drain ? mem_reg[head_reg]
                                                 : (byp ? byp_tag : '0);
        end
    endgenerate

    assign rel.RelReady = rel_ready;
    assign rel.FlWable  = fl_wable;
    assign rel.FlDin    = fl_din;
    assign rel.Idle     = Rest || (&bank_empty);
endmodule

// File: tb/tb_free_tag_dispatcher.sv
// Bench for free_tag_dispatcher: directed scenarios followed by random traffic,
// all checked against a per-bank queue model of the release/drain rules.
module tb_free_tag_dispatcher;
    localparam int TW = 7;

    logic Clk = 1'b0;
    logic Rest;
    logic Flush;

    free_tag_dispatcher_if #(.TAGWIDE(TW)) rel ();

    free_tag_dispatcher #(.TAGWIDE(TW), .STAGEDEEP(4), .STAGEPTR(2)) dut (
        .Clk   (Clk),
        .Rest  (Rest),
        .Flush (Flush),
        .rel   (rel)
    );

    always #5 Clk = ~Clk;

`ifdef FREE_TAG_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    // Model: pending tags per bank, oldest first.
    logic [TW-1:0] q   [4][$];
    logic [TW-1:0] arr [4][$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare outputs with the model, advance the model.
    task automatic step(input bit rst, input bit fl,
                        input bit v0, input logic [TW-1:0] t0,
                        input bit v1, input logic [TW-1:0] t1);
        logic [3:0]      e_wable;
        logic [4*TW-1:0] e_din;
        bit              e_ready;
        bit              e_idle;
        @(negedge Clk);
        cyc++;
        Rest          = rst;
        Flush         = fl;
        rel.RelValid0 = v0;
        rel.RelTag0   = t0;
        rel.RelValid1 = v1;
        rel.RelTag1   = t1;
        #1;
        e_wable = '0;
        e_din   = '0;
        if (rst) begin
            e_ready = 1'b0;
            e_idle  = 1'b1;
        end else begin
            e_idle  = 1'b1;
            e_ready = !fl;
            for (int b = 0; b < 4; b++) begin
                if (q[b].size() != 0) e_idle = 1'b0;
                if (q[b].size() > 2)  e_ready = 1'b0;
                arr[b].delete();
            end
            if (v0 && e_ready && t0 != 0) arr[t0[1:0]].push_back(t0);
            if (v1 && e_ready && t1 != 0) arr[t1[1:0]].push_back(t1);
            if (!fl) begin
                for (int b = 0; b < 4; b++) begin
                    if (q[b].size() > 0) begin
                        e_wable[b] = 1'b1;
                        e_din[b*TW +: TW] = q[b].pop_front();
                    end else if (BYP_EN && arr[b].size() > 0) begin
                        e_wable[b] = 1'b1;
                        e_din[b*TW +: TW] = arr[b].pop_front();
                    end
                    while (arr[b].size() > 0) q[b].push_back(arr[b].pop_front());
                end
            end
        end
        if (rst || fl) begin
            for (int b = 0; b < 4; b++) q[b].delete();
        end
        chk("RelReady", 32'(rel.RelReady), 32'(e_ready));
        chk("Idle",     32'(rel.Idle),     32'(e_idle));
        chk("FlWable",  32'(rel.FlWable),  32'(e_wable));
        chk("FlDin",    32'(rel.FlDin),    32'(e_din));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
    endtask

    initial begin
        logic [TW-1:0] t0, t1;
        bit r, f, v0, v1;
        Rest = 1'b1; Flush = 1'b0;
        rel.RelValid0 = 1'b0; rel.RelTag0 = '0;
        rel.RelValid1 = 1'b0; rel.RelTag1 = '0;

        // Reset for two cycles, then ready and idle.
        step(1, 0, 0, '0, 0, '0);
        chk("rst_wable", 32'(rel.FlWable), 32'd0);
        step(1, 0, 1, 7'd34, 0, '0);
        chk("rst_ready", 32'(rel.RelReady), 32'd0);
        step(0, 0, 0, '0, 0, '0);
        chk("post_rst_ready", 32'(rel.RelReady), 32'd1);
        chk("post_rst_idle",  32'(rel.Idle),     32'd1);

        // Two different banks in one cycle.
        step(0, 0, 1, 7'd34, 1, 7'd39);
`ifdef FREE_TAG_BYPASS_EN
        chk("two_wable", 32'(rel.FlWable), 32'hC);
`else
        step(0, 0, 0, '0, 0, '0);
        chk("two_wable", 32'(rel.FlWable), 32'hC);
        chk("two_din2",  32'(rel.FlDin[2*TW +: TW]), 32'd34);
        chk("two_din3",  32'(rel.FlDin[3*TW +: TW]), 32'd39);
`endif
        step(0, 0, 0, '0, 0, '0);
        chk("two_idle", 32'(rel.Idle), 32'd1);

        // Same-bank burst into bank 2.
        step(0, 0, 1, 7'd42, 1, 7'd46);
        step(0, 0, 1, 7'd50, 1, 7'd54);
`ifndef FREE_TAG_BYPASS_EN
        chk("burst_din42", 32'(rel.FlDin[2*TW +: TW]), 32'd42);
        step(0, 0, 0, '0, 0, '0);
        chk("burst_ready0", 32'(rel.RelReady), 32'd0);
`endif
        idle_cycles(5);

        // Tag zero is swallowed.
        step(0, 0, 1, 7'd0, 0, '0);
        chk("zero_wable", 32'(rel.FlWable), 32'd0);
        idle_cycles(1);
        chk("zero_idle", 32'(rel.Idle), 32'd1);

        // Flush with bank 1 holding three tags.
        step(0, 0, 1, 7'd5, 1, 7'd9);
        step(0, 0, 1, 7'd13, 1, 7'd17);
        step(0, 1, 1, 7'd57, 0, '0);
        chk("flush_wable", 32'(rel.FlWable), 32'd0);
        idle_cycles(1);
        chk("flush_idle", 32'(rel.Idle), 32'd1);
        idle_cycles(2);

        // Empty bank 0 receiving tag 64.
        step(0, 0, 1, 7'd64, 0, '0);
`ifdef FREE_TAG_BYPASS_EN
        chk("byp_wable0", 32'(rel.FlWable[0]), 32'd1);
        chk("byp_din0",   32'(rel.FlDin[0 +: TW]), 32'd64);
`else
        chk("nobyp_wable0", 32'(rel.FlWable[0]), 32'd0);
        idle_cycles(1);
        chk("late_din0", 32'(rel.FlDin[0 +: TW]), 32'd64);
`endif
        idle_cycles(2);

        // Random traffic, biased toward bank collisions.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            f  = ($urandom_range(0, 29) == 0);
            v0 = ($urandom_range(0, 9) < 7);
            v1 = ($urandom_range(0, 9) < 6);
            t0 = 7'($urandom_range(0, 127));
            t1 = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 2) == 0) t1[1:0] = t0[1:0];
            if ($urandom_range(0, 19) == 0) t0 = '0;
            step(r, f, v0, t0, v1, t1);
        end
        idle_cycles(6);
        chk("final_idle", 32'(rel.Idle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
